// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Imported by the arbiter top and its starvation counter.
package mem_port_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_REQ  = 3'd1,
      I_WAIT = 3'd2,
      D_REQ  = 3'd3,
      D_WAIT = 3'd4
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

   localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of data grants issued while a fetch is waiting.
// When the count reaches MAX, the arbiter lets the waiting fetch go first.
module arb_starve_ctr
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_max
);

   localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

   logic [STARVE_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != MAX_C)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_at_max = (r_cnt == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between fetch and the data stage.
// One transaction is in flight at a time; data wins unless fetch is starving.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [DATA_W/8-1:0] dm_wstrb,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic                dm_gnt,
   output logic                dm_rvalid,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_fetch,
   output logic                stall_mem
);

   arb_state_t            r_state;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [DATA_W/8-1:0]   r_mem_wstrb;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [DATA_W-1:0]     r_mem_wdata;

   logic                  w_at_max;
   logic                  w_grant_dm;
   logic                  w_grant_if;
   arb_owner_t            w_owner;

   // Arbitration is decided in the same cycle the request is seen in IDLE.
   assign w_grant_dm = (r_state == IDLE) && dm_req && !(if_req && w_at_max);
   assign w_grant_if = (r_state == IDLE) && if_req && !w_grant_dm;
   assign w_owner    = w_grant_dm ? OWN_DM : OWN_IF;

   arb_starve_ctr #(
      .MAX      (STARVE_MAX)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .i_inc    (w_grant_dm && if_req),
      .i_clr    (w_grant_if || !if_req),
      .o_at_max (w_at_max)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_wstrb <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_dm || w_grant_if) begin
                  r_mem_req <= 1'b1;
                  if (w_owner == OWN_DM) begin
                     r_state     <= D_REQ;
                     r_mem_we    <= dm_we;
                     r_mem_wstrb <= dm_wstrb;
                     r_mem_addr  <= dm_addr;
                     r_mem_wdata <= dm_wdata;
                  end else begin
                     r_state     <= I_REQ;
                     r_mem_we    <= 1'b0;
                     r_mem_wstrb <= '0;
                     r_mem_addr  <= if_addr;
                     r_mem_wdata <= '0;
                  end
               end
            end
            I_REQ: begin
               if (mem_ready) begin
                  r_state   <= I_WAIT;
                  r_mem_req <= 1'b0;
               end
            end
            I_WAIT: begin
               if (mem_rvalid) r_state <= IDLE;
            end
            D_REQ: begin
               if (mem_ready) begin
                  r_state   <= D_WAIT;
                  r_mem_req <= 1'b0;
               end
            end
            D_WAIT: begin
               if (mem_rvalid) r_state <= IDLE;
            end
            default: begin
               r_state   <= IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign if_gnt      = w_grant_if;
   assign dm_gnt      = w_grant_dm;

   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_wstrb   = r_mem_wstrb;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;

   // Responses are only routed in the owner's WAIT state; stray rvalids elsewhere drop.
   assign if_rvalid   = (r_state == I_WAIT) && mem_rvalid;
   assign dm_rvalid   = (r_state == D_WAIT) && mem_rvalid;
   assign if_rdata    = mem_rdata;
   assign dm_rdata    = mem_rdata;

   assign stall_fetch = if_req && !if_rvalid;
   assign stall_mem   = dm_req && !dm_rvalid;

`ifndef SYNTHESIS
   a_ready_rvalid: assert property (@(posedge clk) disable iff (rst)
      (((r_state == I_REQ) || (r_state == D_REQ)) && mem_ready) |-> !mem_rvalid);
   a_if_hold: assert property (@(posedge clk) disable iff (rst)
      ((r_state == I_REQ) || (r_state == I_WAIT)) |-> if_req);
   a_dm_hold: assert property (@(posedge clk) disable iff (rst)
      ((r_state == D_REQ) || (r_state == D_WAIT)) |-> dm_req);
`endif

endmodule
